// File: rtl/a_logic_join.sv
// rtl/a_logic_join.sv - four-phase M-channel join with OP reduction and T-cycle matched delay
// Optional feature: define A_LOGIC_JOIN_ERR_EN to add the sticky protocol-error output err.
module a_logic_join #(
  parameter logic        Rpol = 1'b0,
  parameter int unsigned N    = 32'd1,
  parameter int unsigned M    = 32'd2,
  parameter int unsigned T    = 32'd2,
  parameter logic [1:0]  OP   = 2'd0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   r_i,
  output logic [M-1:0]   a_i,
  input  logic [M*N-1:0] d_i,
  output logic           r_o,
  input  logic           a_o,
  output logic [N-1:0]   d_o
`ifdef A_LOGIC_JOIN_ERR_EN
  ,
  output logic           err
`endif
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EVAL    = 2'd1,
    S_REQ     = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   got_q, got_d;
  logic [M*N-1:0] lat_q, lat_d;
  logic [N-1:0]   dout_q, dout_d;
  logic [31:0]    cnt_q, cnt_d;

  // Polarity-normalised views: 1 means "active" regardless of Rpol.
  logic [M-1:0]   r_act;
  logic           a_o_act;
  logic [M-1:0]   take;
  logic           all_got;
  logic           r_all_idle;
  logic           ack_exit;
  logic [N-1:0]   red;

  assign r_act      = r_i ^ {M{Rpol}};
  assign a_o_act    = a_o ^ Rpol;
  assign take       = (state_q == S_COLLECT) ? (r_act & ~got_q) : '0;
  assign all_got    = &(got_q | take);
  assign r_all_idle = ~|r_act;
  // got is only released once every request and a_o have returned idle, which
  // also guarantees no request still held from the previous round is recaptured.
  assign ack_exit   = (state_q == S_ACK) && r_all_idle && !a_o_act;

  // Capture newly arriving slices; a slice is held until got clears on ACK exit.
  always_comb begin
    lat_d = lat_q;
    got_d = got_q | take;
    for (int k = 0; k < M; k++) begin
      if (take[k]) begin
        lat_d[k*N +: N] = d_i[k*N +: N];
      end
    end
    if (ack_exit) begin
      got_d = '0;
    end
  end

  // Reduce the latched slices, including any captured this very cycle.
  always_comb begin
    red = lat_d[N-1:0];
    for (int k = 1; k < M; k++) begin
      case (OP)
        2'd1:    red = red | lat_d[k*N +: N];
        2'd2:    red = red ^ lat_d[k*N +: N];
        default: red = red & lat_d[k*N +: N];
      endcase
    end
  end

  // Result register loads only when the join completes and leaves COLLECT.
  always_comb begin
    dout_d = dout_q;
    if ((state_q == S_COLLECT) && all_got) begin
      dout_d = red;
    end
  end

  // Next-state logic; EVAL counts T cycles and is bypassed entirely when T is 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_COLLECT: begin
        if (all_got) begin
          cnt_d   = 32'd0;
          state_d = (T == 32'd0) ? S_REQ : S_EVAL;
        end
      end
      S_EVAL: begin
        if (cnt_q == T - 32'd1) begin
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_REQ: begin
        if (a_o_act) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (ack_exit) begin
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_COLLECT;
      got_q   <= '0;
      lat_q   <= '0;
      dout_q  <= '0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      got_q   <= got_d;
      lat_q   <= lat_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decoded from state so reset leaves them idle immediately.
  always_comb begin
    r_o = (state_q == S_REQ) ? ~Rpol : Rpol;
    a_i = (state_q == S_ACK) ? {M{~Rpol}} : {M{Rpol}};
    d_o = dout_q;
  end

`ifdef A_LOGIC_JOIN_ERR_EN
  logic err_q, err_d;
  logic a_o_prev_q;

  // Flag early request withdrawal in COLLECT and any rising a_o outside REQ.
  always_comb begin
    err_d = err_q;
    if ((state_q == S_COLLECT) && |(got_q & ~r_act)) begin
      err_d = 1'b1;
    end
    if (a_o_act && !a_o_prev_q && (state_q != S_REQ)) begin
      err_d = 1'b1;
    end
  end

  // Sticky error register and a_o edge history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q      <= 1'b0;
      a_o_prev_q <= 1'b0;
    end else begin
      err_q      <= err_d;
      a_o_prev_q <= a_o_act;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: doc/a_logic_join.md
A_LOGIC_JOIN -- requirements
Module: a_logic_join

Interface
REQ-001 Parameter Rpol, default 1'b0, idle level of every req/ack wire; the active level is ~Rpol.
REQ-002 Parameter N, default 32'd1, data width per channel.
REQ-003 Parameter M, default 32'd2, number of input channels, M >= 2.
REQ-004 Parameter T, default 32'd2, matched-delay length in clock cycles, T >= 0.
REQ-005 Parameter OP, default 2'd0, reduction operator: 0 AND, 1 OR, 2 XOR, 3 reserved and treated as AND.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 r_i  input  M  per-channel four-phase request.
REQ-009 a_i  output  M  per-channel acknowledge.
REQ-010 d_i  input  M*N  channel k data in bits [k*N +: N].
REQ-011 r_o  output  1  output request.
REQ-012 a_o  input  1  output acknowledge.
REQ-013 d_o  output  N  registered result.
REQ-014 err  output  1  sticky protocol-error flag; present only with A_LOGIC_JOIN_ERR_EN.

Function
REQ-015 The FSM SHALL have states COLLECT, EVAL, REQ and ACK.
REQ-016 In COLLECT, any channel k with r_i[k] active and got[k] clear SHALL latch its data slice and set got[k] in the same cycle.
REQ-017 A captured slice SHALL be held until got is cleared, even if r_i[k] returns idle early.
REQ-018 When every got bit is set, counting captures made that cycle, the FSM SHALL enter EVAL.
REQ-019 On entry to EVAL, d_o SHALL load the OP-reduction of all M latched slices and SHALL stay constant until the next EVAL entry.
REQ-020 EVAL SHALL last exactly T cycles.
REQ-021 With T = 0, EVAL SHALL be skipped and r_o SHALL go active the cycle after the final capture.
REQ-022 In REQ, r_o SHALL be active.
REQ-023 In REQ, a_o active SHALL cause a transition to ACK.
REQ-024 In ACK, r_o SHALL be idle and all a_i bits SHALL be active.
REQ-025 ACK SHALL exit to COLLECT only when every r_i bit is idle and a_o is idle in the same cycle.
REQ-026 On ACK exit, all a_i bits SHALL return to idle and all got bits SHALL clear.
REQ-027 Outside ACK, a_i SHALL be idle.
REQ-028 Outside REQ, r_o SHALL be idle.
REQ-029 A request that stays active after ACK exit SHALL NOT be recaptured until it has been observed idle in ACK.
REQ-030 Channels arriving in different cycles SHALL be joined; the result SHALL be independent of arrival order.

Reset
REQ-031 While rst is low at a clock edge: state = COLLECT, got = 0, latched data = 0, d_o = 0, r_o = Rpol, a_i = {M{Rpol}}, err = 0.
REQ-032 Reset asserted in any state, mid-handshake included, SHALL abandon the transaction; no r_o pulse or a_i pulse SHALL follow release.

Configuration
REQ-033 With A_LOGIC_JOIN_ERR_EN defined, err SHALL set in the cycle after either violation and hold until reset:
- an r_i[k] returns idle in COLLECT after got[k] is set;
- a_o goes active outside REQ.
REQ-034 Without A_LOGIC_JOIN_ERR_EN, port err and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-035 Basic join: N=8, M=2, T=2, OP=0; 0xF0 and 0x3C arrive in the same cycle -> d_o=0x30; r_o active 3 cycles after capture; a_i active the cycle after a_o.
REQ-036 Staggered arrival: M=3, OP=2; 0x01, 0x02, 0x04 arrive 0, 5 and 9 cycles late -> d_o=0x07; no r_o before the third capture.
REQ-037 T=0 with Rpol=1: capture -> r_o low (active) the next cycle; all idle levels read 1 after reset.
REQ-038 Return-to-zero ordering: a_o held active after ACK -> a_i stays active and no new capture occurs until a_o and all r_i are idle.
REQ-039 Reset mid-REQ: rst low for 1 cycle -> r_o idle, d_o=0, state COLLECT, no spurious a_i.
REQ-040 Error flag: with A_LOGIC_JOIN_ERR_EN, withdraw r_i[0] after capture -> err=1 next cycle and sticky; without the macro, the same stimulus gives unchanged data behaviour.
